// File: rtl/seq_bit_serializer.sv
// Purpose : parallel-to-serial feeder for the 101 sequence detector, with a one-word holding buffer.
// Latency : first bit on x one cycle after the accept edge; each bit held DIV cycles, WIDTH*DIV per word.
// Backpr. : load_ready = !hold_full (registered state only); back-to-back words shift out with no gap.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   load_data  word to serialize (sampled only at the accept edge)
//   load_valid producer has a word on load_data
//   load_ready block can take a word this cycle
//   x          serial bit stream (IDLE_BIT when nothing is shifting)
//   bit_valid  x carries a data bit
//   word_done  final cycle of a word's last bit
//   busy       shifter active or holding buffer occupied
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV       = 1,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;

  logic             accept;
  logic             bit_last;
  logic             div_last;
  logic             word_end;
  logic             cur_bit;
  logic [WIDTH-1:0] shreg_shifted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
    end
  end

  // Ready depends only on registered state so the producer never sees a
  // combinational path from its own valid.
  assign load_ready = !hold_full_q;
  assign accept     = load_valid && load_ready;

  assign bit_last = (bit_cnt_q == BIT_LAST);
  assign div_last = (div_cnt_q == DIV_LAST);
  assign word_end = (state_q == SHIFT) && bit_last && div_last;

  // The outgoing bit always sits at one end of the register; shifting
  // toward that end exposes the next bit.
  assign cur_bit       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d   = load_data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // At the word boundary with an empty buffer the new word goes
        // straight into the shifter instead of parking in the buffer.
        if (accept && !word_end) begin
          hold_d      = load_data;
          hold_full_d = 1'b1;
        end

        if (div_last) begin
          div_cnt_d = '0;
          if (bit_last) begin
            bit_cnt_d = '0;
            if (hold_full_q) begin
              shreg_d     = hold_q;
              hold_full_d = 1'b0;
            end else if (accept) begin
              shreg_d = load_data;
            end else begin
              shreg_d = '0;
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            shreg_d   = shreg_shifted;
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign x         = (state_q == SHIFT) ? cur_bit : IDLE_BIT;
  assign bit_valid = (state_q == SHIFT);
  assign word_done = word_end;
  assign busy      = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: u0 uses WIDTH=8 DIV=1 MSB first, u1 uses
// WIDTH=8 DIV=3 LSB first. Outputs are compared as {x,bit_valid,word_done,busy,load_ready}.
module tb_seq_bit_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] d0, d1;
  logic       v0, v1;
  logic       rdy0, rdy1, x0, x1, bv0, bv1, wd0, wd1, busy0, busy1;

  int total = 0;
  int bad   = 0;

  seq_bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u0 (
    .clk(clk), .rst(rst), .load_data(d0), .load_valid(v0), .load_ready(rdy0),
    .x(x0), .bit_valid(bv0), .word_done(wd0), .busy(busy0)
  );

  seq_bit_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u1 (
    .clk(clk), .rst(rst), .load_data(d1), .load_valid(v1), .load_ready(rdy1),
    .x(x1), .bit_valid(bv1), .word_done(wd1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 101 overlapping detector fed by u0's serial stream.
  logic       det_en;
  logic [2:0] hist;
  int         nb;
  int         det_cnt;
  always @(negedge clk) begin
    if (!det_en) begin
      hist    = 3'b000;
      nb      = 0;
      det_cnt = 0;
    end else if (bv0) begin
      hist = {hist[1:0], x0};
      nb   = nb + 1;
      if (nb >= 3 && hist == 3'b101) det_cnt = det_cnt + 1;
    end
  end

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[26];

  // Reference model: each accepted word k has accept cycle a, first-bit
  // cycle s = max(a+1, previous end+1) and end cycle e = s + 8*DIV - 1.
  logic [7:0] src_q[$];
  logic [7:0] w_t[$];
  int         a_t[$], s_t[$], e_t[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic int ref_count(input logic [15:0] s);
    int n = 0;
    for (int i = 0; i < 14; i++)
      if (s[15-i] == 1'b1 && s[14-i] == 1'b0 && s[13-i] == 1'b1) n++;
    return n;
  endfunction

  task automatic run_model(input int sel, input int pct, input string tag);
    int         c, dv, p, snew;
    bit         msb, acc;
    logic       cur_vld;
    logic [7:0] cur_dat;
    logic [4:0] ex, act;
    dv = (sel != 0) ? 3 : 1;
    msb = (sel == 0);
    w_t.delete(); a_t.delete(); s_t.delete(); e_t.delete();
    c = 0;
    cur_vld = 1'b0;
    cur_dat = 8'h00;
    while (1) begin
      ex = 5'b00001;
      for (int k = 0; k < w_t.size(); k++) begin
        if (c >= s_t[k] && c <= e_t[k]) begin
          p = (c - s_t[k]) / dv;
          ex[4] = msb ? w_t[k][7-p] : w_t[k][p];
          ex[3] = 1'b1;
          ex[2] = (c == e_t[k]);
          ex[1] = 1'b1;
        end
        if (c >= a_t[k] + 1 && c <= s_t[k] - 1) begin
          ex[1] = 1'b1;
          ex[0] = 1'b0;
        end
      end
      act = (sel != 0) ? {x1, bv1, wd1, busy1, rdy1} : {x0, bv0, wd0, busy0, rdy0};
      chk($sformatf("%s_c%0d", tag, c), 32'(act), 32'(ex));
      if (src_q.size() == 0 && !cur_vld && (w_t.size() == 0 || c > e_t[$] + 1)) break;
      if (c > 4000) begin
        total++;
        bad++;
        $display("FAIL %s_timeout got=%0d want=<=4000 cycles", tag, c);
        break;
      end
      if (!cur_vld && src_q.size() > 0 && $urandom_range(99) < pct) begin
        cur_vld = 1'b1;
        cur_dat = src_q.pop_front();
      end
      if (sel != 0) begin
        v1 = cur_vld;
        d1 = cur_vld ? cur_dat : 8'($urandom);
      end else begin
        v0 = cur_vld;
        d0 = cur_vld ? cur_dat : 8'($urandom);
      end
      acc = cur_vld && ex[0];
      if (acc) begin
        snew = c + 1;
        if (e_t.size() > 0 && e_t[$] + 1 > snew) snew = e_t[$] + 1;
        w_t.push_back(cur_dat);
        a_t.push_back(c);
        s_t.push_back(snew);
        e_t.push_back(snew + 8 * dv - 1);
      end
      tick();
      if (acc) cur_vld = 1'b0;
      c++;
    end
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  initial begin
    logic [4:0] ex;

    tbl[0]  = '{1'b1, 8'hB5, 5'b11011};  tbl[1]  = '{1'b0, 8'h00, 5'b01011};
    tbl[2]  = '{1'b0, 8'h00, 5'b11011};  tbl[3]  = '{1'b0, 8'h00, 5'b11011};
    tbl[4]  = '{1'b0, 8'h00, 5'b01011};  tbl[5]  = '{1'b0, 8'h00, 5'b11011};
    tbl[6]  = '{1'b0, 8'h00, 5'b01011};  tbl[7]  = '{1'b0, 8'h00, 5'b11111};
    tbl[8]  = '{1'b0, 8'h00, 5'b00001};  tbl[9]  = '{1'b1, 8'hA5, 5'b11011};
    tbl[10] = '{1'b1, 8'h3C, 5'b01010};  tbl[11] = '{1'b0, 8'h00, 5'b11010};
    tbl[12] = '{1'b0, 8'h00, 5'b01010};  tbl[13] = '{1'b0, 8'h00, 5'b01010};
    tbl[14] = '{1'b0, 8'h00, 5'b11010};  tbl[15] = '{1'b0, 8'h00, 5'b01010};
    tbl[16] = '{1'b0, 8'h00, 5'b11110};  tbl[17] = '{1'b0, 8'h00, 5'b01011};
    tbl[18] = '{1'b0, 8'h00, 5'b01011};  tbl[19] = '{1'b0, 8'h00, 5'b11011};
    tbl[20] = '{1'b0, 8'h00, 5'b11011};  tbl[21] = '{1'b0, 8'h00, 5'b11011};
    tbl[22] = '{1'b0, 8'h00, 5'b11011};  tbl[23] = '{1'b0, 8'h00, 5'b01011};
    tbl[24] = '{1'b0, 8'h00, 5'b01111};  tbl[25] = '{1'b0, 8'h00, 5'b00001};

    det_en = 1'b0;
    rst = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    d0 = 8'h00; d1 = 8'h00;

    // Reset state
    #3;
    chk("rst_u0", 32'({x0, bv0, wd0, busy0, rdy0}), 32'(5'b00001));
    chk("rst_u1", 32'({x1, bv1, wd1, busy1, rdy1}), 32'(5'b00001));
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_u0", 32'({x0, bv0, wd0, busy0, rdy0}), 32'(5'b00001));

    // Single word, then back-to-back A5/3C through the holding buffer
    for (int i = 0; i < 26; i++) begin
      v0 = tbl[i].vld;
      d0 = tbl[i].vld ? tbl[i].dat : 8'($urandom);
      tick();
      chk($sformatf("tbl_r%0d", i), 32'({x0, bv0, wd0, busy0, rdy0}), 32'(tbl[i].exp));
    end
    v0 = 1'b0;

    // DIV=3, LSB first, word 8'h01: three 1-cycles then 21 zero cycles
    v1 = 1'b1;
    d1 = 8'h01;
    tick();
    v1 = 1'b0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      if (cyc <= 24) ex = {(cyc <= 3), 1'b1, (cyc == 24), 2'b11};
      else           ex = 5'b00001;
      chk($sformatf("div3_c%0d", cyc), 32'({x1, bv1, wd1, busy1, rdy1}), 32'(ex));
      tick();
    end

    // Asynchronous reset in the middle of a word
    v0 = 1'b1;
    d0 = 8'hFF;
    tick();
    v0 = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_busy", 32'({bv0, busy0}), 32'(2'b11));
    #2 rst = 1'b0;
    #1;
    chk("async_rst", 32'({x0, bv0, wd0, busy0, rdy0}), 32'(5'b00001));
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("after_rst_c%0d", i), 32'({x0, bv0, wd0, busy0, rdy0}), 32'(5'b00001));
    end

    // Holding buffer full with a third word pending
    src_q = '{8'hC3, 8'h5A, 8'h96};
    run_model(0, 100, "hold");
    chk("hold_naccepted", 32'(w_t.size()), 32'd3);
    if (w_t.size() == 3) begin
      chk("hold_w3_accept", 32'(a_t[2]), 32'(e_t[0] + 1));
      chk("hold_gapless", 32'(s_t[2]), 32'(e_t[1] + 1));
    end

    // Two words feeding the detector across the word boundary
    det_en = 1'b1;
    src_q = '{8'b0111_0100, 8'b1010_1000};
    run_model(0, 100, "det");
    chk("det_cnt_model", 32'(det_cnt), 32'(ref_count({8'b0111_0100, 8'b1010_1000})));
    chk("det_cnt_three", 32'(det_cnt), 32'd3);
    det_en = 1'b0;

    // Randomized traffic on both configurations
    for (int i = 0; i < 30; i++) src_q.push_back(8'($urandom));
    run_model(0, 60, "rnd0");
    for (int i = 0; i < 30; i++) src_q.push_back(8'($urandom));
    run_model(0, 100, "rnd0f");
    for (int i = 0; i < 20; i++) src_q.push_back(8'($urandom));
    run_model(1, 50, "rnd1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
